fpu_round_pack: RTL and testbench

- Two-stage pipelined normalize/round/pack stage directly downstream of the FP multiplier (and, later, the FP adder).
- Consumes the unpacked product (sign, unbiased exponent, double-width normalized significand, 6-bit class, rounding mode) plus a pre-packed special-case result.
- Produces the IEEE-754 packed result and RISC-V exception flags (NV/DZ/OF/UF/NX) under valid/ready handshakes.
- Keeps the sticky accrued-flags register that feeds fcsr.fflags.

---
 rtl/fpu_round_pack_pkg.sv | 34 +++
 rtl/fpu_round_pack_inc.sv | 27 ++
 rtl/fpu_round_pack.sv | 193 +++++++++++++++++++
 tb/tb_fpu_round_pack.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_round_pack_pkg.sv
// Shared constants for the FP round/pack stage: rounding-mode codes,
// fflags bit positions and the one-hot FClassFlags class encoding.
package fpu_round_pack_pkg;

    // Rounding-mode codes (codes 101-111 are treated as RNE)
    localparam logic [2:0] RM_RNE = 3'b000;
    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;

    // Bit positions inside the {NV,DZ,OF,UF,NX} flag vector
    localparam int FFLAG_NX = 0;
    localparam int FFLAG_UF = 1;
    localparam int FFLAG_OF = 2;
    localparam int FFLAG_DZ = 3;
    localparam int FFLAG_NV = 4;

    // One-hot operand/result classes
    localparam logic [5:0] CLS_ZERO    = 6'b000001;
    localparam logic [5:0] CLS_SUBNORM = 6'b000010;
    localparam logic [5:0] CLS_NORMAL  = 6'b000100;
    localparam logic [5:0] CLS_INF     = 6'b001000;
    localparam logic [5:0] CLS_QNAN    = 6'b010000;
    localparam logic [5:0] CLS_SNAN    = 6'b100000;

    // Classes whose packed result comes pre-built from upstream
    localparam logic [5:0] CLS_SPECIAL = CLS_ZERO | CLS_INF | CLS_QNAN | CLS_SNAN;

    function automatic logic is_special(input logic [5:0] cls);
        return |(cls & CLS_SPECIAL);
    endfunction

endpackage

// File: rtl/fpu_round_pack_inc.sv
// Rounding increment decision: given the rounding mode, the sign, the
// mantissa LSB and the guard/sticky bits, decide whether to add one ulp.
module fpu_round_inc
    import fpu_round_pack_pkg::*;
(
    input  logic [2:0] i_rm,
    input  logic       i_sign,
    input  logic       i_lsb,
    input  logic       i_g,
    input  logic       i_s,
    output logic       o_inc
);

    // Per-mode increment; unknown modes fall back to round-to-nearest-even
    always_comb begin
        o_inc = 1'b0;
        case (i_rm)
            RM_RNE:  o_inc = i_g & (i_s | i_lsb);
            RM_RTZ:  o_inc = 1'b0;
            RM_RDN:  o_inc = i_sign & (i_g | i_s);
            RM_RUP:  o_inc = !i_sign & (i_g | i_s);
            RM_RMM:  o_inc = i_g;
            default: o_inc = i_g & (i_s | i_lsb);
        endcase
    end

endmodule

// File: rtl/fpu_round_pack.sv
// Two-stage normalize/round/pack stage behind the FP multiplier.
// S1 denormalizes tiny results and extracts mantissa/guard/sticky,
// S2 rounds, detects overflow/underflow and packs the IEEE-754 word.
// Optional macro FPU_SUB_FLUSH_EN: flush would-be subnormal results to +-0.
module fpu_round_pack
    import fpu_round_pack_pkg::*;
#(
    parameter  int FLEN     = 32,
    localparam int NEXP     = (FLEN == 64) ? 11 : 8,
    localparam int NSIG     = (FLEN == 64) ? 52 : 23,
    localparam int NFULLSIG = 2 * NSIG + 1,
    localparam int EMIN     = 2 - 2 ** (NEXP - 1),
    localparam int EMAX     = 2 ** (NEXP - 1) - 1,
    localparam int BIAS     = EMAX
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic                   sign_i,
    input  logic signed [NEXP+2:0] exp_i,
    input  logic [NFULLSIG:0]      sig_i,
    input  logic [5:0]             class_i,
    input  logic [FLEN-1:0]        special_i,
    input  logic                   invalid_i,
    input  logic [2:0]             rm_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [FLEN-1:0]        result_o,
    output logic [4:0]             fflags_o,
    input  logic                   clear_fflags_i,
    output logic [4:0]             acc_fflags_o
);

    localparam int SHCLAMP = NFULLSIG + 2;
    localparam int SHW     = $clog2(SHCLAMP + 1);
    localparam int EW      = NEXP + 4;
    localparam int EXW     = 2 * NFULLSIG + 3;
    localparam int GPOS    = NFULLSIG - NSIG - 1;

    // Overflowed result: infinity when the mode rounds away from zero, else max-finite
    function automatic logic [FLEN-1:0] sat_overflow(input logic sgn, input logic [2:0] rm);
        logic to_inf;
        case (rm)
            RM_RTZ:  to_inf = 1'b0;
            RM_RDN:  to_inf = sgn;
            RM_RUP:  to_inf = !sgn;
            default: to_inf = 1'b1;
        endcase
        return to_inf ? {sgn, {NEXP{1'b1}}, {NSIG{1'b0}}}
                      : {sgn, {(NEXP-1){1'b1}}, 1'b0, {NSIG{1'b1}}};
    endfunction

    logic                 r_vld_p1, r_vld_p2;
    logic                 r_byp_p1, r_sign_p1, r_g_p1, r_s_p1, r_nv_p1;
    logic [2:0]           r_rm_p1;
    logic [EW-1:0]        r_bexp_p1;
    logic [NSIG:0]        r_mant_p1;
    logic [FLEN-1:0]      r_spec_p1;
    logic [FLEN-1:0]      r_result_p2;
    logic [4:0]           r_fflags_p2;
    logic [4:0]           r_acc;

    logic                 w_s2_adv, w_in_fire, w_out_fire;
    logic                 w_tiny;
    logic signed [31:0]   w_shdiff;
    logic [SHW-1:0]       w_shamt;
    logic [EXW-1:0]       w_ext;
    logic [NFULLSIG:0]    w_den;
    logic                 w_shst;
    logic [EW-1:0]        w_bexp;

    logic                 w_inc, w_carry, w_nx, w_ovf;
    logic [NSIG+1:0]      w_sum;
    logic [EW-1:0]        w_exp_r;
    logic [NSIG-1:0]      w_frac;
    logic [FLEN-1:0]      w_res;
    logic [4:0]           w_flags;

    assign w_s2_adv   = !r_vld_p2 | out_ready_i;
    assign in_ready_o = !r_vld_p1 | w_s2_adv;
    assign w_in_fire  = in_valid_i & in_ready_o;
    assign w_out_fire = r_vld_p2 & out_ready_i;

    // ---- S1: denormalize tiny results, split mantissa / guard / sticky ----
    assign w_tiny   = int'(exp_i) < EMIN;
    assign w_shdiff = EMIN - int'(exp_i);
    assign w_shamt  = !w_tiny ? '0
                    : (w_shdiff > SHCLAMP) ? SHW'(SHCLAMP) : SHW'(w_shdiff);
    assign w_ext    = {sig_i, {SHCLAMP{1'b0}}} >> w_shamt;
    assign w_den    = w_ext[EXW-1 -: NFULLSIG+1];
    assign w_shst   = |w_ext[SHCLAMP-1:0];
    assign w_bexp   = w_tiny ? '0 : EW'(int'(exp_i) + BIAS);

    // S1 valid: advances whenever the stage can accept
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_vld_p1 <= 1'b0;
        end else if (in_ready_o) begin
            r_vld_p1 <= in_valid_i;
        end
    end

    // S1 data: captured only on an accepted input, held while stalled
    always_ff @(posedge clk_i) begin
        if (w_in_fire) begin
            r_byp_p1  <= is_special(class_i);
            r_spec_p1 <= special_i;
            r_nv_p1   <= invalid_i;
            r_sign_p1 <= sign_i;
            r_rm_p1   <= rm_i;
            r_bexp_p1 <= w_bexp;
            r_mant_p1 <= w_den[NFULLSIG -: NSIG+1];
            r_g_p1    <= w_den[GPOS];
            r_s_p1    <= (|w_den[GPOS-1:0]) | w_shst;
        end
    end

    // ---- S2: round, overflow/underflow detection, pack ----
    fpu_round_inc u_inc (
        .i_rm   (r_rm_p1),
        .i_sign (r_sign_p1),
        .i_lsb  (r_mant_p1[0]),
        .i_g    (r_g_p1),
        .i_s    (r_s_p1),
        .o_inc  (w_inc)
    );

    // A subnormal rounding into the hidden bit lands on exponent field 1;
    // a normal carry-out bumps the exponent and leaves a zero fraction.
    assign w_sum   = {1'b0, r_mant_p1} + {{(NSIG+1){1'b0}}, w_inc};
    assign w_carry = w_sum[NSIG+1];
    assign w_exp_r = (r_bexp_p1 == '0) ? EW'(w_sum[NSIG]) : r_bexp_p1 + EW'(w_carry);
    assign w_frac  = w_carry ? '0 : w_sum[NSIG-1:0];
    assign w_nx    = r_g_p1 | r_s_p1;
    assign w_ovf   = w_exp_r >= EW'(2 ** NEXP - 1);

    // Packed result and flags, with the special-case bypass taking priority
    always_comb begin
        w_res                = {r_sign_p1, w_exp_r[NEXP-1:0], w_frac};
        w_flags              = '0;
        w_flags[FFLAG_DZ]    = 1'b0;
        w_flags[FFLAG_NX]    = w_nx;
        if (w_ovf) begin
            w_res             = sat_overflow(r_sign_p1, r_rm_p1);
            w_flags[FFLAG_OF] = 1'b1;
            w_flags[FFLAG_NX] = 1'b1;
        end else if (w_exp_r == '0) begin
`ifdef FPU_SUB_FLUSH_EN
            w_res             = {r_sign_p1, {(FLEN-1){1'b0}}};
            w_flags[FFLAG_UF] = 1'b1;
            w_flags[FFLAG_NX] = 1'b1;
`else
            w_flags[FFLAG_UF] = w_nx;
`endif
        end
        if (r_byp_p1) begin
            w_res             = r_spec_p1;
            w_flags           = '0;
            w_flags[FFLAG_NV] = r_nv_p1;
        end
    end

    // S2 output register: loads from S1 when downstream has room
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_vld_p2    <= 1'b0;
            r_result_p2 <= '0;
            r_fflags_p2 <= '0;
        end else if (w_s2_adv) begin
            r_vld_p2 <= r_vld_p1;
            if (r_vld_p1) begin
                r_result_p2 <= w_res;
                r_fflags_p2 <= w_flags;
            end
        end
    end

    // Sticky accrued flags; a same-cycle clear and fire keeps the new flags
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_acc <= '0;
        end else begin
            r_acc <= (clear_fflags_i ? 5'b0 : r_acc) | (w_out_fire ? r_fflags_p2 : 5'b0);
        end
    end

    assign out_valid_o  = r_vld_p2;
    assign result_o     = r_result_p2;
    assign fflags_o     = r_fflags_p2;
    assign acc_fflags_o = r_acc;

endmodule

// File: tb/tb_fpu_round_pack.sv
// Bench for fpu_round_pack (FLEN=32): directed checks of the rounding,
// overflow, underflow, handshake and accrued-flag behaviour, then random
// traffic against a value-level rounding model.
module tb_fpu_round_pack;
    import fpu_round_pack_pkg::*;

    localparam int FLEN = 32;
    localparam logic [47:0] SIG_ONE = 48'h8000_0000_0000;
    localparam logic [47:0] SIG_TIE = 48'hFFFF_FF80_0000;

    logic               clk = 1'b0;
    logic               rst_i;
    logic               in_valid_i, in_ready_o;
    logic               sign_i;
    logic signed [10:0] exp_i;
    logic [47:0]        sig_i;
    logic [5:0]         class_i;
    logic [31:0]        special_i;
    logic               invalid_i;
    logic [2:0]         rm_i;
    logic               out_valid_o, out_ready_i;
    logic [31:0]        result_o;
    logic [4:0]         fflags_o;
    logic               clear_fflags_i;
    logic [4:0]         acc_fflags_o;

    int total = 0;
    int bad   = 0;
    logic [4:0]  acc_m = '0;
    logic [36:0] sb[$];

    always #5 clk = ~clk;

    fpu_round_pack #(.FLEN(FLEN)) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .in_valid_i     (in_valid_i),
        .in_ready_o     (in_ready_o),
        .sign_i         (sign_i),
        .exp_i          (exp_i),
        .sig_i          (sig_i),
        .class_i        (class_i),
        .special_i      (special_i),
        .invalid_i      (invalid_i),
        .rm_i           (rm_i),
        .out_valid_o    (out_valid_o),
        .out_ready_i    (out_ready_i),
        .result_o       (result_o),
        .fflags_o       (fflags_o),
        .clear_fflags_i (clear_fflags_i),
        .acc_fflags_o   (acc_fflags_o)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    // Value-level model: value = sig * 2^(e-47) is divided by the quantum of
    // the target binade (never finer than the subnormal quantum) and the
    // quotient is rounded from the remainder.
    function automatic logic [36:0] ref_model(input logic sgn, input int e,
                                              input logic [47:0] sg, input logic [2:0] rm);
        int q, sh, bexp;
        longint unsigned m, rem, half, one;
        logic gt, eq, nz, up, inf;
        logic [31:0] res;
        logic [4:0] fl;
        one = 1;
        q   = ((e > -126) ? e : -126) - 23;
        sh  = q - (e - 47);
        gt  = 1'b0;
        eq  = 1'b0;
        if (sh < 64) begin
            m    = {16'b0, sg} >> sh;
            rem  = {16'b0, sg} & ((one << sh) - 1);
            half = one << (sh - 1);
            gt   = rem > half;
            eq   = rem == half;
        end else begin
            m   = 0;
            rem = {16'b0, sg};
        end
        nz = rem != 0;
        case (rm)
            3'd1:    up = 1'b0;
            3'd2:    up = sgn & nz;
            3'd3:    up = !sgn & nz;
            3'd4:    up = gt | eq;
            default: up = gt | (eq & m[0]);
        endcase
        m = m + 64'(up);
        if (m == (one << 24)) begin
            m = one << 23;
            q++;
        end
        if (m >= (one << 23)) begin
            bexp = q + 23 + 127;
            m    = m - (one << 23);
        end else begin
            bexp = 0;
        end
        fl = {4'b0, nz};
        if (bexp >= 255) begin
            fl  = 5'b00101;
            inf = (rm == 3'd1) ? 1'b0 : (rm == 3'd2) ? sgn : (rm == 3'd3) ? !sgn : 1'b1;
            res = inf ? {sgn, 8'hFF, 23'h0} : {sgn, 8'hFE, 23'h7FFFFF};
        end else begin
            res = {sgn, 8'(bexp), 23'(m)};
            if (bexp == 0) begin
                fl[1] = nz;
`ifdef FPU_SUB_FLUSH_EN
                res = {sgn, 31'b0};
                fl  = 5'b00011;
`endif
            end
        end
        return {res, fl};
    endfunction

    task automatic drive(input logic sgn, input int e, input logic [47:0] sg,
                         input logic [5:0] cls, input logic [31:0] spc,
                         input logic inv, input logic [2:0] rm);
        sign_i    = sgn;
        exp_i     = 11'(e);
        sig_i     = sg;
        class_i   = cls;
        special_i = spc;
        invalid_i = inv;
        rm_i      = rm;
    endtask

    // One transaction through an empty pipe: latency, result, flags, accrued flags
    task automatic directed(input string tag, input logic sgn, input int e,
                            input logic [47:0] sg, input logic [5:0] cls,
                            input logic [31:0] spc, input logic inv, input logic [2:0] rm,
                            input logic [31:0] er, input logic [4:0] ef);
        int n;
        drive(sgn, e, sg, cls, spc, inv, rm);
        in_valid_i  = 1'b1;
        out_ready_i = 1'b1;
        #1;
        check_val({tag, "_rdy"}, in_ready_o, 1);
        @(posedge clk); @(negedge clk);
        in_valid_i = 1'b0;
        n = 1;
        while (!out_valid_o && n < 8) begin
            @(posedge clk); @(negedge clk);
            n++;
        end
        #1;
        check_val({tag, "_lat"}, n, 2);
        check_val({tag, "_res"}, result_o, er);
        check_val({tag, "_flg"}, fflags_o, ef);
        acc_m = acc_m | ef;
        @(posedge clk); @(negedge clk);
        #1;
        check_val({tag, "_acc"}, acc_fflags_o, acc_m);
    endtask

    // Random-phase cycle: score an output fire, queue an accepted input
    task automatic step();
        logic [36:0] e;
        logic ofire;
        #1;
        check_val("acc", acc_fflags_o, acc_m);
        ofire = out_valid_o & out_ready_i;
        e = '0;
        if (ofire) begin
            if (sb.size() == 0) begin
                check_val("spurious_out", 1, 0);
            end else begin
                e = sb.pop_front();
                check_val("rnd_res", result_o, e[36:5]);
                check_val("rnd_flg", fflags_o, e[4:0]);
            end
        end
        if (in_valid_i && in_ready_o) begin
            if (class_i != CLS_NORMAL)
                sb.push_back({special_i, invalid_i, 4'b0});
            else
                sb.push_back(ref_model(sign_i, int'(exp_i), sig_i, rm_i));
        end
        acc_m = (clear_fflags_i ? 5'b0 : acc_m) | (ofire ? e[4:0] : 5'b0);
        @(posedge clk); @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got[$];
        int acc_cnt;
        int sel, e;
        logic [47:0] sg;
        logic [5:0]  cls;

        rst_i = 1'b1; in_valid_i = 1'b0; out_ready_i = 1'b1; clear_fflags_i = 1'b0;
        drive(1'b0, 0, SIG_ONE, CLS_NORMAL, 32'h0, 1'b0, RM_RNE);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_ovld", out_valid_o, 0);
        check_val("rst_res", result_o, 0);
        check_val("rst_flg", fflags_o, 0);
        check_val("rst_acc", acc_fflags_o, 0);
        rst_i = 1'b0;

        // Reset while a transaction is in flight discards it
        in_valid_i = 1'b1;
        @(posedge clk); @(negedge clk);
        in_valid_i = 1'b0; rst_i = 1'b1;
        @(posedge clk); @(negedge clk);
        rst_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 check_val("midrst_ovld", out_valid_o, 0);
            @(posedge clk); @(negedge clk);
        end

        directed("one",     1'b0,    0, SIG_ONE, CLS_NORMAL, 0, 1'b0, RM_RNE, 32'h3F800000, 5'b00000);
        directed("tie_rne", 1'b0,    0, SIG_TIE, CLS_NORMAL, 0, 1'b0, RM_RNE, 32'h40000000, 5'b00001);
        directed("tie_rtz", 1'b0,    0, SIG_TIE, CLS_NORMAL, 0, 1'b0, RM_RTZ, 32'h3FFFFFFF, 5'b00001);
        directed("ovf_rne", 1'b0,  128, SIG_ONE, CLS_NORMAL, 0, 1'b0, RM_RNE, 32'h7F800000, 5'b00101);
        directed("ovf_rtz", 1'b0,  128, SIG_ONE, CLS_NORMAL, 0, 1'b0, RM_RTZ, 32'h7F7FFFFF, 5'b00101);
        directed("ovf_rup", 1'b1,  128, SIG_ONE, CLS_NORMAL, 0, 1'b0, RM_RUP, 32'hFF7FFFFF, 5'b00101);
`ifdef FPU_SUB_FLUSH_EN
        directed("sub_127", 1'b0, -127, SIG_ONE, CLS_NORMAL, 0, 1'b0, RM_RNE, 32'h00000000, 5'b00011);
        directed("sub_rne", 1'b0, -150, SIG_ONE, CLS_NORMAL, 0, 1'b0, RM_RNE, 32'h00000000, 5'b00011);
        directed("sub_rup", 1'b0, -150, SIG_ONE, CLS_NORMAL, 0, 1'b0, RM_RUP, 32'h00000000, 5'b00011);
`else
        directed("sub_127", 1'b0, -127, SIG_ONE, CLS_NORMAL, 0, 1'b0, RM_RNE, 32'h00400000, 5'b00000);
        directed("sub_rne", 1'b0, -150, SIG_ONE, CLS_NORMAL, 0, 1'b0, RM_RNE, 32'h00000000, 5'b00011);
        directed("sub_rup", 1'b0, -150, SIG_ONE, CLS_NORMAL, 0, 1'b0, RM_RUP, 32'h00000001, 5'b00011);
`endif
        directed("qnan",    1'b0,    0, SIG_ONE, CLS_QNAN, 32'h7FC00000, 1'b1, RM_RNE, 32'h7FC00000, 5'b10000);

        // Clear in the same cycle as an NX output fire leaves only NX
        drive(1'b0, 0, SIG_TIE, CLS_NORMAL, 0, 1'b0, RM_RTZ);
        in_valid_i = 1'b1; out_ready_i = 1'b1;
        @(posedge clk); @(negedge clk);
        in_valid_i = 1'b0;
        @(posedge clk); @(negedge clk);
        #1 check_val("clr_ovld", out_valid_o, 1);
        check_val("clr_res", result_o, 32'h3FFFFFFF);
        clear_fflags_i = 1'b1;
        @(posedge clk); @(negedge clk);
        clear_fflags_i = 1'b0;
        #1 check_val("clr_acc", acc_fflags_o, 5'b00001);
        acc_m = 5'b00001;

        // Back-pressure: three offers with the sink stalled for three cycles
        out_ready_i = 1'b0;
        acc_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, i, SIG_ONE, CLS_NORMAL, 0, 1'b0, RM_RNE);
            in_valid_i = 1'b1;
            #1;
            if (in_ready_o) acc_cnt++;
            if (i == 2) check_val("bp_rdy", in_ready_o, 0);
            @(posedge clk); @(negedge clk);
        end
        in_valid_i = 1'b0;
        check_val("bp_acc", acc_cnt, 2);
        #1 check_val("bp_hold", result_o, 32'h3F800000);
        out_ready_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (out_valid_o) got.push_back(result_o);
            @(posedge clk); @(negedge clk);
        end
        check_val("bp_cnt", got.size(), 2);
        if (got.size() == 2) begin
            check_val("bp_o0", got[0], 32'h3F800000);
            check_val("bp_o1", got[1], 32'h40000000);
        end

        // Random traffic against the model
        clear_fflags_i = 1'b1;
        #1;
        @(posedge clk); @(negedge clk);
        clear_fflags_i = 1'b0;
        acc_m = '0;
        for (int c = 0; c < 600; c++) begin
            sel = int'($urandom_range(0, 4));
            case (sel)
                0:       e = int'($urandom_range(0, 40)) - 160;
                1:       e = int'($urandom_range(0, 8)) - 130;
                2:       e = int'($urandom_range(0, 10)) + 120;
                default: e = int'($urandom_range(0, 60)) - 30;
            endcase
            sg = {1'b1, 15'($urandom), $urandom};
            if ($urandom_range(0, 3) == 0) sg[22:0] = '0;
            if ($urandom_range(0, 5) == 0) sg[46:0] = 47'($urandom_range(0, 1)) << 23;
            cls = CLS_NORMAL;
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 3))
                    0:       cls = CLS_QNAN;
                    1:       cls = CLS_SNAN;
                    2:       cls = CLS_INF;
                    default: cls = CLS_ZERO;
                endcase
            end
            drive(1'($urandom), e, sg, cls, $urandom, 1'($urandom), 3'($urandom_range(0, 7)));
            in_valid_i     = ($urandom_range(0, 3) != 0);
            out_ready_i    = ($urandom_range(0, 3) != 0);
            clear_fflags_i = ($urandom_range(0, 15) == 0);
            step();
        end
        in_valid_i = 1'b0; out_ready_i = 1'b1; clear_fflags_i = 1'b0;
        for (int i = 0; i < 20 && sb.size() != 0; i++) step();
        check_val("drain", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
